// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file sizing, arbitration pointer type and writeback record
package cpu_pkg;
  localparam int BUS_WIDTH = 8;
  localparam int DATA_WIDTH = BUS_WIDTH;
  localparam int NUMBER_OF_REGISTERS = 16;
  localparam int REG_AW = $clog2(NUMBER_OF_REGISTERS);
  localparam int WB_DEPTH = 4;
  typedef enum logic {RR_ALU, RR_TENSOR} rr_t;
  typedef struct packed {
    logic [REG_AW-1:0] address;
    logic signed [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/cpu_wb_fifo.sv
// cpu_wb_fifo: in-order writeback entry storage with per-entry lookup match vectors (index 0 = oldest)
module cpu_wb_fifo #(
  parameter int AW = cpu_pkg::REG_AW,
  parameter int DW = cpu_pkg::DATA_WIDTH,
  parameter int DEPTH = cpu_pkg::WB_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic [AW-1:0] push_address,
  input  logic [DW-1:0] push_data,
  input  logic pop,
  input  logic [AW-1:0] lookup1,
  input  logic [AW-1:0] lookup2,
  output logic [AW-1:0] head_address,
  output logic [DW-1:0] head_data,
  output logic [PW:0] count,
  output logic [DEPTH-1:0] match1,
  output logic [DEPTH-1:0] match2,
  output logic [DEPTH-1:0][DW-1:0] age_data
);
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] count_q, count_d;
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (push && !flush) begin
      addr_d[wr_q] = push_address;
      data_d[wr_q] = push_data;
    end
    rd_d = flush ? '0 : rd_q + PW'(pop);
    wr_d = flush ? '0 : wr_q + PW'(push);
    count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  always_comb begin
    match1 = '0;
    match2 = '0;
    age_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_data[i] = data_q[PW'(rd_q + PW'(i))];
      match1[i] = ((PW+1)'(i) < count_q) && addr_q[PW'(rd_q + PW'(i))] == lookup1;
      match2[i] = ((PW+1)'(i) < count_q) && addr_q[PW'(rd_q + PW'(i))] == lookup2;
    end
  end
  assign head_address = addr_q[rd_q];
  assign head_data = data_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/cpu_writeback_queue.sv
// cpu_writeback_queue: arbitrates ALU/tensor results into an in-order queue feeding the
// register-file write port, and forwards pending values to the operand-read stage.
module cpu_writeback_queue #(
  parameter int NUMBER_OF_REGISTERS = cpu_pkg::NUMBER_OF_REGISTERS,
  parameter int DEPTH = cpu_pkg::WB_DEPTH,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  localparam int AW = $clog2(NUMBER_OF_REGISTERS),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic alu_valid_in,
  output logic alu_ready_out,
  input  logic [AW-1:0] alu_address_in,
  input  logic [DATA_WIDTH-1:0] alu_data_in,
  input  logic tensor_valid_in,
  output logic tensor_ready_out,
  input  logic [AW-1:0] tensor_address_in,
  input  logic [DATA_WIDTH-1:0] tensor_data_in,
  input  logic commit_enable_in,
  input  logic flush_in,
  output logic write_enable_out,
  output logic [AW-1:0] write_address_out,
  output logic [DATA_WIDTH-1:0] write_data_out,
  input  logic [AW-1:0] lookup_address1_in,
  input  logic [AW-1:0] lookup_address2_in,
  output logic forward_hit1_out,
  output logic forward_hit2_out,
  output logic [DATA_WIDTH-1:0] forward_data1_out,
  output logic [DATA_WIDTH-1:0] forward_data2_out,
  output logic [CW-1:0] count_out
);
  import cpu_pkg::*;
  rr_t rr_q, rr_d;
  logic we_q, we_d;
  logic [AW-1:0] wa_q, wa_d, push_address, head_address;
  logic [DATA_WIDTH-1:0] wd_q, wd_d, push_data, head_data;
  logic pop, room, grant_tensor, fire, push;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] match1, match2;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] age_data;
  cpu_wb_fifo #(.AW(AW), .DW(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clock_in),
    .rst_n(reset_n_in),
    .flush(flush_in),
    .push(push),
    .push_address(push_address),
    .push_data(push_data),
    .pop(pop),
    .lookup1(lookup_address1_in),
    .lookup2(lookup_address2_in),
    .head_address(head_address),
    .head_data(head_data),
    .count(count),
    .match1(match1),
    .match2(match2),
    .age_data(age_data)
  );
  // Writes to r0 complete the handshake but are never enqueued.
  always_comb begin
    pop = commit_enable_in && count != '0;
    room = count < CW'(DEPTH) || pop;
    grant_tensor = tensor_valid_in && (!alu_valid_in || rr_q == RR_TENSOR);
    alu_ready_out = reset_n_in && alu_valid_in && !grant_tensor && room;
    tensor_ready_out = reset_n_in && grant_tensor && room;
    fire = alu_ready_out || tensor_ready_out;
    push_address = tensor_ready_out ? tensor_address_in : alu_address_in;
    push_data = tensor_ready_out ? tensor_data_in : alu_data_in;
    push = fire && push_address != '0;
    rr_d = fire ? rr_t'(~rr_q) : rr_q;
    we_d = pop && !flush_in;
    wa_d = we_d ? head_address : wa_q;
    wd_d = we_d ? head_data : wd_q;
  end
  always_ff @(posedge clock_in or negedge reset_n_in)
    if (!reset_n_in) begin
      rr_q <= RR_ALU;
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      rr_q <= rr_d;
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  // Output stage is the oldest candidate; later (younger) queue matches override it.
  function automatic logic [DATA_WIDTH:0] forward(input logic [AW-1:0] lookup, input logic [DEPTH-1:0] match);
    logic [DATA_WIDTH:0] r;
    r = (we_q && wa_q == lookup) ? {1'b1, wd_q} : '0;
    for (int i = 0; i < DEPTH; i++)
      if (match[i]) r = {1'b1, age_data[i]};
    return lookup == '0 ? '0 : r;
  endfunction
  always_comb begin
    {forward_hit1_out, forward_data1_out} = forward(lookup_address1_in, match1);
    {forward_hit2_out, forward_data2_out} = forward(lookup_address2_in, match2);
  end
  assign write_enable_out = we_q;
  assign write_address_out = wa_q;
  assign write_data_out = wd_q;
  assign count_out = count;
endmodule

// File: tb/tb_cpu_writeback_queue.sv
// tb_cpu_writeback_queue: directed vector table, reset corners and queue-model random run
module tb_cpu_writeback_queue;
  import cpu_pkg::*;
  localparam int AW = REG_AW;
  localparam int DW = DATA_WIDTH;
  localparam int DEPTH = WB_DEPTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic av = 1'b0, tv = 1'b0, ce = 1'b0, fl = 1'b0;
  logic [AW-1:0] aa = '0, ta = '0, l1 = '0, l2 = '0;
  logic [DW-1:0] ad = '0, td = '0;
  logic ar, tr, we, h1, h2;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd, f1, f2;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  cpu_writeback_queue dut (
    .clock_in(clk), .reset_n_in(rst_n),
    .alu_valid_in(av), .alu_ready_out(ar), .alu_address_in(aa), .alu_data_in(ad),
    .tensor_valid_in(tv), .tensor_ready_out(tr), .tensor_address_in(ta), .tensor_data_in(td),
    .commit_enable_in(ce), .flush_in(fl),
    .write_enable_out(we), .write_address_out(wa), .write_data_out(wd),
    .lookup_address1_in(l1), .lookup_address2_in(l2),
    .forward_hit1_out(h1), .forward_hit2_out(h2),
    .forward_data1_out(f1), .forward_data2_out(f2),
    .count_out(cnt)
  );

  typedef struct {
    logic av; logic [AW-1:0] aa; logic [DW-1:0] ad;
    logic tv; logic [AW-1:0] ta; logic [DW-1:0] td;
    logic ce, fl; logic [AW-1:0] l1, l2;
    logic ar, tr, h1; logic [DW-1:0] f1; logic h2; logic [DW-1:0] f2;
    logic we; logic [AW-1:0] wa; logic [DW-1:0] wd; logic [CW-1:0] cnt;
  } vec_t;

  int passed = 0, total = 0;
  vec_t tbl[$];

  wb_entry_t mq[$];
  logic m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  bit m_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t idle();
    vec_t v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t row(logic a_v, logic [AW-1:0] a_a, logic [DW-1:0] a_d,
                               logic t_v, logic [AW-1:0] t_a, logic [DW-1:0] t_d,
                               logic c, logic f, logic [AW-1:0] lk,
                               logic e_ar, logic e_tr, logic e_h1, logic [DW-1:0] e_f1,
                               logic e_we, logic [AW-1:0] e_wa, logic [DW-1:0] e_wd, logic [CW-1:0] e_cnt);
    vec_t v = idle();
    v.av = a_v; v.aa = a_a; v.ad = a_d; v.tv = t_v; v.ta = t_a; v.td = t_d;
    v.ce = c; v.fl = f; v.l1 = lk;
    v.ar = e_ar; v.tr = e_tr; v.h1 = e_h1; v.f1 = e_f1;
    v.we = e_we; v.wa = e_wa; v.wd = e_wd; v.cnt = e_cnt;
    return v;
  endfunction

  task automatic run(input vec_t v);
    av = v.av; aa = v.aa; ad = v.ad; tv = v.tv; ta = v.ta; td = v.td;
    ce = v.ce; fl = v.fl; l1 = v.l1; l2 = v.l2;
    #1;
    chk("alu_ready", ar, v.ar);
    chk("tensor_ready", tr, v.tr);
    chk("hit1", h1, v.h1);
    chk("fwd_data1", f1, v.f1);
    chk("hit2", h2, v.h2);
    chk("fwd_data2", f2, v.f2);
    @(posedge clk);
    #1;
    chk("write_enable", we, v.we);
    chk("write_address", wa, v.wa);
    chk("write_data", wd, v.wd);
    chk("count", cnt, v.cnt);
    @(negedge clk);
  endtask

  function automatic logic [DW:0] m_fwd(logic [AW-1:0] lk);
    if (lk == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].address == lk) return {1'b1, mq[i].data};
    if (m_we && m_wa == lk) return {1'b1, m_wd};
    return '0;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_rr = 1'b0;
  endtask

  // Fills expected values from the queue model, then advances it by one clock.
  task automatic model(inout vec_t v);
    bit popv, room, ga, gt, acc;
    wb_entry_t e, h;
    popv = v.ce && mq.size() > 0;
    room = mq.size() < DEPTH || popv;
    ga = v.av && !(v.tv && m_rr);
    gt = v.tv && !ga;
    v.ar = ga && room;
    v.tr = gt && room;
    {v.h1, v.f1} = m_fwd(v.l1);
    {v.h2, v.f2} = m_fwd(v.l2);
    acc = v.ar || v.tr;
    e.address = v.tr ? v.ta : v.aa;
    e.data = v.tr ? v.td : v.ad;
    if (v.fl) begin
      mq.delete();
      m_we = 1'b0;
    end else begin
      m_we = popv;
      if (popv) begin
        h = mq.pop_front();
        m_wa = h.address;
        m_wd = h.data;
      end
      if (acc && e.address != '0) mq.push_back(e);
    end
    if (acc) m_rr = !m_rr;
    v.we = m_we; v.wa = m_wa; v.wd = m_wd; v.cnt = CW'(mq.size());
  endtask

  initial begin
    vec_t v;
    tbl.push_back(row(1,3,8'hFB, 1,6,8'h11, 1,0,3, 1,0,0,8'h00, 0,0,8'h00,1));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,3, 0,0,1,8'hFB, 1,3,8'hFB,0));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,3, 0,0,1,8'hFB, 0,3,8'hFB,0));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,3, 0,0,0,8'h00, 0,3,8'hFB,0));
    tbl.push_back(row(1,1,8'h01, 0,0,8'h00, 0,0,1, 1,0,0,8'h00, 0,3,8'hFB,1));
    tbl.push_back(row(0,0,8'h00, 1,2,8'h02, 0,0,1, 0,1,1,8'h01, 0,3,8'hFB,2));
    tbl.push_back(row(1,1,8'h07, 0,0,8'h00, 0,0,1, 1,0,1,8'h01, 0,3,8'hFB,3));
    tbl.push_back(row(1,4,8'h04, 0,0,8'h00, 0,0,1, 1,0,1,8'h07, 0,3,8'hFB,4));
    tbl.push_back(row(1,5,8'h55, 0,0,8'h00, 0,0,1, 0,0,1,8'h07, 0,3,8'hFB,4));
    tbl.push_back(row(1,5,8'h55, 0,0,8'h00, 1,0,4, 1,0,1,8'h04, 1,1,8'h01,4));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,1, 0,0,1,8'h07, 1,2,8'h02,3));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,2, 0,0,1,8'h02, 1,1,8'h07,2));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,0, 0,0,0,8'h00, 1,4,8'h04,1));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,5, 0,0,1,8'h55, 1,5,8'h55,0));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,5, 0,0,1,8'h55, 0,5,8'h55,0));
    tbl.push_back(row(1,0,8'h09, 0,0,8'h00, 1,0,0, 1,0,0,8'h00, 0,5,8'h55,0));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,0, 0,0,0,8'h00, 0,5,8'h55,0));
    tbl.push_back(row(1,5,8'h15, 1,6,8'h26, 0,0,6, 0,1,0,8'h00, 0,5,8'h55,1));
    tbl.push_back(row(1,5,8'h15, 1,6,8'h26, 0,0,6, 1,0,1,8'h26, 0,5,8'h55,2));
    tbl.push_back(row(1,5,8'h15, 1,6,8'h26, 0,0,5, 0,1,1,8'h15, 0,5,8'h55,3));
    tbl.push_back(row(0,0,8'h00, 1,2,8'h03, 0,1,6, 0,1,1,8'h26, 0,5,8'h55,0));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,2, 0,0,0,8'h00, 0,5,8'h55,0));
    tbl.push_back(row(1,5,8'h15, 1,6,8'h26, 1,0,6, 0,1,0,8'h00, 0,5,8'h55,1));
    tbl.push_back(row(1,5,8'h15, 1,6,8'h26, 1,0,6, 1,0,1,8'h26, 1,6,8'h26,1));
    tbl.push_back(row(1,5,8'h15, 1,6,8'h26, 1,0,5, 0,1,1,8'h15, 1,5,8'h15,1));
    tbl.push_back(row(0,0,8'h00, 0,0,8'h00, 1,0,6, 0,0,1,8'h26, 1,6,8'h26,0));

    // Reset held with both producers valid and commit enabled
    av = 1; aa = 3; ad = 8'hFB; tv = 1; ta = 6; td = 8'h11; ce = 1; l1 = 3;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_alu_ready", ar, 1'b0);
    chk("rst_tensor_ready", tr, 1'b0);
    chk("rst_write_enable", we, 1'b0);
    chk("rst_write_address", wa, '0);
    chk("rst_write_data", wd, '0);
    chk("rst_count", cnt, '0);
    chk("rst_hit1", h1, 1'b0);
    chk("rst_fwd_data1", f1, '0);
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) run(tbl[i]);

    // Reset asserted mid-operation drops queued entries and the output stage
    rst_n = 0;
    run(idle());
    rst_n = 1;
    m_reset();
    v = idle(); v.av = 1; v.aa = 7; v.ad = 8'h77; model(v); run(v);
    v = idle(); v.av = 1; v.aa = 8; v.ad = 8'h88; v.ce = 1; v.l1 = 8; model(v); run(v);
    chk("pre_rst_write_enable", we, 1'b1);
    chk("pre_rst_count", cnt, CW'(1));
    av = 1; aa = 9; l1 = 8; l2 = 7;
    rst_n = 0;
    #1;
    chk("mid_rst_count", cnt, '0);
    chk("mid_rst_write_enable", we, 1'b0);
    chk("mid_rst_write_address", wa, '0);
    chk("mid_rst_write_data", wd, '0);
    chk("mid_rst_hit1", h1, 1'b0);
    chk("mid_rst_hit2", h2, 1'b0);
    chk("mid_rst_alu_ready", ar, 1'b0);
    @(negedge clk);
    rst_n = 1;
    m_reset();

    for (int c = 0; c < 800; c++) begin
      v = idle();
      v.av = 1'($urandom_range(0, 1));
      v.aa = AW'($urandom_range(0, NUMBER_OF_REGISTERS - 1));
      v.ad = DW'($urandom);
      v.tv = 1'($urandom_range(0, 1));
      v.ta = AW'($urandom_range(0, NUMBER_OF_REGISTERS - 1));
      v.td = DW'($urandom);
      v.ce = $urandom_range(0, 99) < (((c / 50) % 2 == 1) ? 25 : 80);
      v.fl = $urandom_range(0, 39) == 0;
      v.l1 = AW'($urandom_range(0, NUMBER_OF_REGISTERS - 1));
      v.l2 = AW'($urandom_range(0, NUMBER_OF_REGISTERS - 1));
      model(v);
      run(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpu_writeback_queue.md
Name: cpu_writeback_queue

Overview:
- Sits directly upstream of the CPU register file and drives its single write port (enable, address, data).
- Accepts results from two producers, the scalar ALU and the tensor-core result path, over valid/ready handshakes.
- Buffers results in order in a small FIFO and commits one write per cycle when the core permits.
- Gives the operand-read stage forwarding data and hit flags for writes still pending, so reads never see stale register-file values.

Parameters:
- NUMBER_OF_REGISTERS, 16, register count; address width AW = $clog2(NUMBER_OF_REGISTERS).
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- DATA_WIDTH, 8, signed data width; matches the register-file bus.

Ports:
- clock_in  in  1  single clock, all state on posedge.
- reset_n_in  in  1  asynchronous, active-low reset.
- alu_valid_in  in  1  ALU result valid.
- alu_ready_out  out  1  ALU result accepted this cycle.
- alu_address_in  in  AW  ALU destination register.
- alu_data_in  in  DATA_WIDTH  ALU result, signed.
- tensor_valid_in  in  1  tensor result valid.
- tensor_ready_out  out  1  tensor result accepted this cycle.
- tensor_address_in  in  AW  tensor destination register.
- tensor_data_in  in  DATA_WIDTH  tensor result, signed.
- commit_enable_in  in  1  allows the queue to pop one entry this cycle.
- flush_in  in  1  synchronous discard of all pending writes.
- write_enable_out  out  1  to register file write enable; registered.
- write_address_out  out  AW  to register file write address; registered.
- write_data_out  out  DATA_WIDTH  to register file write data; registered.
- lookup_address1_in  in  AW  operand-read port 1 address.
- lookup_address2_in  in  AW  operand-read port 2 address.
- forward_hit1_out  out  1  a pending write matches lookup address 1.
- forward_hit2_out  out  1  a pending write matches lookup address 2.
- forward_data1_out  out  DATA_WIDTH  youngest pending value for lookup address 1.
- forward_data2_out  out  DATA_WIDTH  youngest pending value for lookup address 2.
- count_out  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty; count_out = 0; write_enable_out = 0; write_address_out = 0; write_data_out = 0; round-robin pointer = ALU; all forward outputs = 0. Reset mid-operation drops every pending entry, including the output stage.
- Arbitration: at most one push per cycle. When both producers are valid, a round-robin pointer decides the winner, and the pointer toggles only on a granted push.
- Readiness: the winner's ready is 1 iff count < DEPTH, or a pop occurs in the same cycle. The loser's ready is 0. A lone valid producer wins outright.
- Register 0: a handshake with address 0 completes (ready = 1 by the rule above), but nothing is enqueued. Register 0 is hard-wired zero.
- Pop: occurs iff commit_enable_in = 1 and count > 0. The head entry loads the output registers with write_enable_out = 1 on the following cycle. With no pop, write_enable_out = 0 next cycle and address/data hold their values.
- Latency: push at edge N → earliest write_enable_out high in cycle N+1..N+2 → register file commits at edge N+2.
- Simultaneous push and pop: count is unchanged, and a full FIFO still accepts a push.
- Ordering: entries leave in acceptance order. Pointers wrap modulo DEPTH.
- Flush: at the next edge, empties the FIFO and clears write_enable_out. A push in the same cycle is discarded, but its ready is still reported as 1.
- Forwarding (combinational):
  - Search set is the FIFO entries plus the output stage while write_enable_out = 1.
  - The youngest matching entry wins; the output stage is the oldest.
  - Lookup address 0 never hits; it returns hit = 0 and data = 0.
  - No hit gives data = 0.
- Arithmetic: none. Data passes bit-exact, signed.

Decomposition:
- Package cpu_pkg holds BUS_WIDTH-derived DATA_WIDTH, NUMBER_OF_REGISTERS, and the typedef wb_entry_t {address, data}.
- One sub-module, cpu_wb_fifo (entry storage, pointers, count, per-entry address-match vector). Arbitration, output stage and forwarding live in the top level.

Test Plan:
- Reset with both producers valid → all outputs 0, no write pulses; release → ALU (pointer default) accepted first.
- ALU writes r3 = -5 with commit_enable_in = 1 → write_enable_out high for one cycle with address 3, data 8'hFB; lookup r3 hits with -5 until commit.
- commit_enable_in = 0; push r1 = 1, r2 = 2, r1 = 7, r4 = 4 → count_out = 4, ready = 0 on a 5th push, lookup r1 returns 7; enable commit → pulses r1, r2, r1, r4 in order.
- Both producers valid continuously, ALU → r5, tensor → r6 → grants alternate ALU, tensor, ALU…; commit order matches grant order.
- Write to r0 = 9 → handshake completes, count_out stays 0, no write pulse; lookup r0 gives hit = 0.
- Three entries queued, then flush_in = 1 while the tensor pushes r2 = 3 → next cycle count_out = 0 and write_enable_out = 0; r2 never committed.
